// File: rtl/shift_unit_iter_if.sv
// Request/response bus of the iterative shift unit.
// The optional carry_out signal exists only when SHIFT_CARRY_EN is defined.
interface shift_unit_iter_if #(
  parameter int WIDTH = 32
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amnt;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
`ifdef SHIFT_CARRY_EN
  logic             carry_out;
`endif

  // Requester / consumer side
  modport master (
    output in_valid, a, amnt, op, out_ready,
    input  in_ready, out_valid, result
`ifdef SHIFT_CARRY_EN
    , input carry_out
`endif
  );

  // Shift unit side
  modport slave (
    input  in_valid, a, amnt, op, out_ready,
    output in_ready, out_valid, result
`ifdef SHIFT_CARRY_EN
    , output carry_out
`endif
  );
endinterface

// File: rtl/shift_unit_iter.sv
// Multi-cycle shift unit: SRL / SRA / SLL / ROR on WIDTH-bit operands,
// advancing up to STEP bit positions per clock, valid/ready on both sides.
// Optional feature macro: SHIFT_CARRY_EN adds a registered carry_out holding
// the last bit shifted out.
module shift_unit_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  shift_unit_iter_if.slave  bus
);
  localparam int AMT_W = $clog2(WIDTH);
  // STEP only matters when the remaining count exceeds it, so it always fits AMT_W here
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] remaining;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] k;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_c;

  // One step of the selected shift by k positions (1 <= k <= WIDTH-1)
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [AMT_W-1:0] amt,
                                                  input logic [1:0]       opc);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (opc)
      OP_SRL:  return v >> amt;
      OP_SRA:  return sv >>> amt;
      OP_SLL:  return v << amt;
      default: return (v >> amt) | (v << (AMT_W'(WIDTH) - amt));
    endcase
  endfunction

  // Bit that leaves the word in a step of amt positions
  function automatic logic step_carry(input logic [WIDTH-1:0] v,
                                      input logic [AMT_W-1:0] amt,
                                      input logic [1:0]       opc);
    if (opc == OP_SLL) return v[AMT_W'(WIDTH) - amt];
    else               return v[amt - AMT_W'(1)];
  endfunction

  assign k      = (int'(remaining) > STEP) ? STEP_A : remaining;
  assign accept = bus.in_valid & in_ready_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.amnt == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining == k) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE:    in_ready_c  = ~reset;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = work;

  // Capture on accept, then walk the working register down to zero remaining
  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      remaining <= '0;
      op_q      <= OP_SRL;
    end else begin
      case (state)
        IDLE: if (accept) begin
          work      <= bus.a;
          remaining <= bus.amnt;
          op_q      <= bus.op;
        end
        SHIFT: begin
          work      <= shift_step(work, k, op_q);
          remaining <= remaining - k;
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_CARRY_EN
  logic carry_q;

  // Track the most recent bit shifted out; cleared on capture so amnt=0 gives 0
  always_ff @(posedge clk) begin
    if (reset) carry_q <= 1'b0;
    else if (state == IDLE && accept) carry_q <= 1'b0;
    else if (state == SHIFT) carry_q <= step_carry(work, k, op_q);
  end

  assign bus.carry_out = carry_q;
`endif

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter (WIDTH=32, STEP=4).
module tb_shift_unit_iter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [1:0] SRL = 2'b00, SRA = 2'b01, SLL = 2'b10, ROR = 2'b11;

  shift_unit_iter_if #(.WIDTH(32)) bus();

  shift_unit_iter #(.WIDTH(32), .STEP(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge, measure latency, check result, optionally stall the consumer
  task automatic run_op(input string tag, input logic [31:0] av, input logic [4:0] am,
                        input logic [1:0] opv, input logic [31:0] er, input logic ec,
                        input int el, input bit bp);
    int lat;
    bit ready_seen;
    @(negedge clk);
    bus.a = av; bus.amnt = am; bus.op = opv; bus.in_valid = 1'b1;
    #1 check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~av; bus.op = ~opv; bus.amnt = ~am;
    lat = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(el));
    check({tag, "_busy_in_ready"}, 64'(ready_seen | bus.in_ready), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'(er));
`ifdef SHIFT_CARRY_EN
    check({tag, "_carry"}, 64'(bus.carry_out), 64'(ec));
`else
    if (ec === 1'bx) $display("unexpected carry argument");
`endif
    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        bus.in_valid = ~bus.in_valid;
        bus.a = $urandom;
        @(negedge clk);
        check({tag, "_bp_result"}, 64'(bus.result), 64'(er));
        check({tag, "_bp_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_bp_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = 32'hDEAD_BEEF; bus.amnt = 5'd3; bus.op = SRL;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef SHIFT_CARRY_EN
    check("rst_carry", 64'(bus.carry_out), 64'd0);
`endif
    reset = 1'b0;
    bus.out_ready = 1'b0;

    run_op("sra4",    32'h8000_00F0, 5'd4,  SRA, 32'hF800_000F, 1'b0, 2, 1'b0);
    run_op("srl31",   32'h8000_0000, 5'd31, SRL, 32'h0000_0001, 1'b0, 9, 1'b0);
    run_op("sll1",    32'h8000_0001, 5'd1,  SLL, 32'h0000_0002, 1'b1, 2, 1'b0);
    run_op("sll0",    32'h8000_0001, 5'd0,  SLL, 32'h8000_0001, 1'b0, 1, 1'b0);
    run_op("ror1",    32'h0000_0001, 5'd1,  ROR, 32'h8000_0000, 1'b1, 2, 1'b0);
    run_op("ror8",    32'h1234_5678, 5'd8,  ROR, 32'h7812_3456, 1'b0, 3, 1'b0);
    run_op("sra31",   32'hF000_0000, 5'd31, SRA, 32'hFFFF_FFFF, 1'b1, 9, 1'b0);
    run_op("sll9",    32'h0000_00FF, 5'd9,  SLL, 32'h0001_FE00, 1'b0, 4, 1'b0);
    run_op("srl9",    32'h0000_0100, 5'd9,  SRL, 32'h0000_0000, 1'b1, 4, 1'b0);
    run_op("ror5",    32'h0000_001F, 5'd5,  ROR, 32'hF800_0000, 1'b1, 3, 1'b0);
    run_op("bp_srl4", 32'hA5A5_A5A5, 5'd4,  SRL, 32'h0A5A_5A5A, 1'b0, 2, 1'b1);

    // Abort a long shift part way through
    @(negedge clk);
    bus.a = 32'hFFFF_FFFF; bus.amnt = 5'd20; bus.op = SLL; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_in_ready_rst", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    #1 check("abort_in_ready_idle", 64'(bus.in_ready), 64'd1);
    run_op("after_abort", 32'h1234_5678, 5'd8, ROR, 32'h7812_3456, 1'b0, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
